// File: rtl/queue_calc_sequencer.sv
// Token-stream sequencer for the queue calculator: turns operand/operator/emit tokens into
// queue push / pair-replace / pop steps, with an 8-bit ALU on the queue's front pair.
module queue_calc_sequencer #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tok_valid_i,
    output logic           tok_ready_o,
    input  logic [1:0]     tok_kind_i,
    input  logic [W-1:0]   tok_data_i,
    input  logic [2*W-1:0] q_top_i,
    output logic           q_valid_o,
    output logic [1:0]     q_opcode_o,
    output logic [W-1:0]   q_back_o,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [W-1:0]   out_data_o,
    output logic [2:0]     count_o,
    output logic [1:0]     err_o,
    output logic           busy_o
);

    typedef enum logic [2:0] {
        StIdle, StPush, StAlu, StIssue, StEmit, StPop, StErr
    } state_e;

    localparam logic [2:0] DepthC    = 3'(DEPTH);
    localparam logic [1:0] OpPush    = 2'b00;
    localparam logic [1:0] OpPair    = 2'b10;
    localparam logic [1:0] OpPop     = 2'b11;
    localparam logic [1:0] ErrOvf    = 2'b01;
    localparam logic [1:0] ErrUnd    = 2'b10;
    localparam logic [1:0] ErrIllegal = 2'b11;

    state_e         state_q, state_d;
    logic [2:0]     count_q, count_d;
    logic [1:0]     err_q, err_d;
    logic [1:0]     op_q, op_d;
    logic           q_valid_q, q_valid_d;
    logic [1:0]     q_opcode_q, q_opcode_d;
    logic [W-1:0]   q_back_q, q_back_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   alu_a, alu_b, alu_res;

    assign alu_a = q_top_i[2*W-1:W];
    assign alu_b = q_top_i[W-1:0];

    // All ops wrap modulo 2^W; mul keeps only the low W bits of the product.
    always_comb begin
        unique case (op_q)
            2'b00:   alu_res = alu_a + alu_b;
            2'b01:   alu_res = alu_a - alu_b;
            2'b10:   alu_res = alu_a * alu_b;
            default: alu_res = alu_a ^ alu_b;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        op_d        = op_q;
        q_valid_d   = 1'b0;
        q_opcode_d  = 2'b00;
        q_back_d    = '0;
        out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tok_valid_i) begin
                    unique case (tok_kind_i)
                        2'b00: begin
                            if (count_q == DepthC) begin
                                err_d   = ErrOvf;
                                state_d = StErr;
                            end else begin
                                state_d    = StPush;
                                q_valid_d  = 1'b1;
                                q_opcode_d = OpPush;
                                q_back_d   = tok_data_i;
                            end
                        end
                        2'b01: begin
                            if (count_q < 3'd2) begin
                                err_d   = ErrUnd;
                                state_d = StErr;
                            end else begin
                                op_d    = tok_data_i[1:0];
                                state_d = StAlu;
                            end
                        end
                        2'b10: begin
                            if (count_q == 3'd0) begin
                                err_d   = ErrUnd;
                                state_d = StErr;
                            end else begin
                                state_d     = StEmit;
                                out_valid_d = 1'b1;
                            end
                        end
                        default: begin
                            err_d   = ErrIllegal;
                            state_d = StErr;
                        end
                    endcase
                end
            end
            StPush: begin
                count_d = count_q + 3'd1;
                state_d = StIdle;
            end
            StAlu: begin
                state_d    = StIssue;
                q_valid_d  = 1'b1;
                q_opcode_d = OpPair;
                q_back_d   = alu_res;
            end
            StIssue: begin
                count_d = count_q - 3'd1;
                state_d = StIdle;
            end
            StEmit: begin
                if (out_ready_i) begin
                    state_d    = StPop;
                    q_valid_d  = 1'b1;
                    q_opcode_d = OpPop;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            StPop: begin
                count_d = count_q - 3'd1;
                state_d = StIdle;
            end
            StErr: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= 3'd0;
            err_q       <= 2'b00;
            op_q        <= 2'b00;
            q_valid_q   <= 1'b0;
            q_opcode_q  <= 2'b00;
            q_back_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            op_q        <= op_d;
            q_valid_q   <= q_valid_d;
            q_opcode_q  <= q_opcode_d;
            q_back_q    <= q_back_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign tok_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign q_valid_o   = q_valid_q;
    assign q_opcode_o  = q_opcode_q;
    assign q_back_o    = q_back_q;
    assign out_valid_o = out_valid_q;
    // Queue is frozen while emitting, so the front entry is stable for the whole handshake.
    assign out_data_o  = q_top_i[2*W-1:W];
    assign count_o     = count_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_queue_calc_sequencer.sv
// Bench for queue_calc_sequencer: a small 8-entry queue answers the DUT's steps, and a
// token-level reference model predicts every queue step, emitted value, count and error.
module tb_queue_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic [1:0]  tok_kind = 2'b00;
    logic [7:0]  tok_data = 8'h00;
    logic [15:0] q_top;
    logic        q_valid;
    logic [1:0]  q_opcode;
    logic [7:0]  q_back;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [2:0]  count;
    logic [1:0]  err;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int m_q[$];

    queue_calc_sequencer #(.W(8), .DEPTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .tok_valid_i (tok_valid),
        .tok_ready_o (tok_ready),
        .tok_kind_i  (tok_kind),
        .tok_data_i  (tok_data),
        .q_top_i     (q_top),
        .q_valid_o   (q_valid),
        .q_opcode_o  (q_opcode),
        .q_back_o    (q_back),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .count_o     (count),
        .err_o       (err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Operand queue the DUT drives: push to back, pair -> result at back, pop front.
    logic [7:0] env_q [0:7];
    int         env_n = 0;
    initial for (int i = 0; i < 8; i++) env_q[i] = 8'h00;
    assign q_top = {env_q[0], env_q[1]};

    always @(posedge clk) begin
        if (rst) begin
            env_n <= 0;
        end else if (q_valid) begin
            case (q_opcode)
                2'b00: if (env_n < 8) begin
                    env_q[env_n] <= q_back;
                    env_n <= env_n + 1;
                end
                2'b10: if (env_n >= 2) begin
                    for (int i = 0; i < 6; i++) env_q[i] <= env_q[i+2];
                    env_q[env_n-2] <= q_back;
                    env_n <= env_n - 1;
                end
                2'b11: if (env_n >= 1) begin
                    for (int i = 0; i < 7; i++) env_q[i] <= env_q[i+1];
                    env_n <= env_n - 1;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_calc(input logic [1:0] op, input int a, input int b);
        int r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a * b;
            default: r = a ^ b;
        endcase
        return r[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_q_valid", q_valid, 0);
        check("rst_q_opcode", q_opcode, 0);
        check("rst_q_back", q_back, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tok_ready", tok_ready, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tok_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        m_q.delete();
        check_reset_state();
    endtask

    task automatic drive_tok(input logic [1:0] kind, input logic [7:0] data);
        int t = 0;
        while (!tok_ready && t < 10) begin
            tick();
            t++;
        end
        check("tok_ready_wait", tok_ready, 1);
        tok_valid = 1'b1;
        tok_kind  = kind;
        tok_data  = data;
        tick();
        tok_valid = 1'b0;
        tok_data  = 8'($urandom);
    endtask

    task automatic err_path(input logic [1:0] code);
        check("err_code", err, code);
        check("err_tok_ready", tok_ready, 0);
        check("err_q_valid", q_valid, 0);
        check("err_out_valid", out_valid, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("err_frozen_q_valid", q_valid, 0);
            check("err_frozen_count", count, m_q.size());
            check("err_frozen_err", err, code);
        end
        do_reset();
    endtask

    task automatic do_token(input logic [1:0] kind, input logic [7:0] data, input int hold);
        int a, b, e;
        logic [7:0] r;
        drive_tok(kind, data);
        case (kind)
            2'b00: begin
                if (m_q.size() == 5) begin
                    err_path(2'b01);
                end else begin
                    m_q.push_back(int'(data));
                    check("push_q_valid", q_valid, 1);
                    check("push_opcode", q_opcode, 0);
                    check("push_back", q_back, data);
                    check("push_tok_ready", tok_ready, 0);
                    tick();
                    check("push_done_q_valid", q_valid, 0);
                    check("push_count", count, m_q.size());
                    check("push_idle", tok_ready, 1);
                end
            end
            2'b01: begin
                if (m_q.size() < 2) begin
                    err_path(2'b10);
                end else begin
                    a = m_q.pop_front();
                    b = m_q.pop_front();
                    r = ref_calc(data[1:0], a, b);
                    m_q.push_back(int'(r));
                    check("alu_q_valid", q_valid, 0);
                    check("alu_busy", busy, 1);
                    tick();
                    check("issue_q_valid", q_valid, 1);
                    check("issue_opcode", q_opcode, 2);
                    check("issue_back", q_back, r);
                    tick();
                    check("issue_done_q_valid", q_valid, 0);
                    check("issue_count", count, m_q.size());
                end
            end
            2'b10: begin
                if (m_q.size() == 0) begin
                    err_path(2'b10);
                end else begin
                    e = m_q.pop_front();
                    check("emit_out_valid", out_valid, 1);
                    check("emit_out_data", out_data, e);
                    for (int i = 0; i < hold; i++) begin
                        tick();
                        check("emit_hold_valid", out_valid, 1);
                        check("emit_hold_data", out_data, e);
                    end
                    out_ready = 1'b1;
                    tick();
                    out_ready = 1'b0;
                    check("pop_out_valid", out_valid, 0);
                    check("pop_q_valid", q_valid, 1);
                    check("pop_opcode", q_opcode, 3);
                    check("pop_back", q_back, 0);
                    tick();
                    check("pop_done_q_valid", q_valid, 0);
                    check("pop_count", count, m_q.size());
                end
            end
            default: err_path(2'b11);
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sel;
        logic [1:0] k;
        do_reset();

        do_token(2'b00, 8'd7, 0);
        do_token(2'b00, 8'd3, 0);
        do_token(2'b01, 8'd0, 0);
        check("add_count_one", count, 1);
        do_token(2'b10, 8'd0, 0);

        do_token(2'b00, 8'd3, 0);
        do_token(2'b00, 8'd7, 0);
        do_token(2'b01, 8'd1, 0);
        do_token(2'b10, 8'd0, 1);

        do_token(2'b00, 8'd20, 0);
        do_token(2'b00, 8'd13, 0);
        do_token(2'b01, 8'd2, 0);
        do_token(2'b10, 8'd0, 0);

        do_token(2'b00, 8'hF0, 0);
        do_token(2'b00, 8'h3C, 0);
        do_token(2'b01, 8'h03, 0);
        do_token(2'b10, 8'd0, 2);

        do_token(2'b00, 8'd42, 0);
        do_token(2'b10, 8'd0, 3);

        for (int i = 0; i < 5; i++) do_token(2'b00, 8'(10 + i), 0);
        do_token(2'b00, 8'd99, 0);

        do_token(2'b00, 8'd1, 0);
        do_token(2'b01, 8'd0, 0);
        do_token(2'b10, 8'd0, 0);
        do_token(2'b11, 8'd0, 0);

        // Reset while an emit is waiting on the consumer.
        do_token(2'b00, 8'd9, 0);
        drive_tok(2'b10, 8'd0);
        check("mid_emit_valid", out_valid, 1);
        do_reset();

        // Reset while the pair-replace step is on the queue port.
        do_token(2'b00, 8'd1, 0);
        do_token(2'b00, 8'd2, 0);
        drive_tok(2'b01, 8'd0);
        tick();
        check("mid_issue_valid", q_valid, 1);
        do_reset();

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 45)      k = 2'b00;
            else if (sel < 75) k = 2'b01;
            else if (sel < 98) k = 2'b10;
            else               k = 2'b11;
            do_token(k, 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
